// File: rtl/safe_pkg.sv
// ============================================================================
// Module  : safe_pkg
// Brief   : Shared types and constants for the safe-mode hart sync agent.
// Revision: 1.0
// ============================================================================
`default_nettype none

package safe_pkg;

  typedef enum logic [2:0] {
    AG_IDLE     = 3'd0,
    AG_HALT_REQ = 3'd1,
    AG_HALT_ACK = 3'd2,
    AG_IRQ_REQ  = 3'd3,
    AG_IRQ_ACK  = 3'd4
  } safe_agent_fsm_e;

  localparam int         SAFE_IRQ_ID_W    = 5;
  localparam logic [4:0] SAFE_SYNC_IRQ_ID = 5'd31;

endpackage

`default_nettype wire

// File: rtl/safe_hart_sync_agent_if.sv
// ============================================================================
// Module  : safe_hart_sync_agent_if
// Brief   : Agent <-> core handshake bundle (debug halt, sync IRQ, sleep).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface safe_hart_sync_agent_if;
  import safe_pkg::*;

  logic                     core_debug_req_o;
  logic                     core_debug_halted_i;
  logic                     core_sleep_i;
  logic                     core_irq_o;
  logic                     core_irq_ack_i;
  logic [SAFE_IRQ_ID_W-1:0] core_irq_id_i;

  // master = the sync agent, slave = the core
  modport master (
    output core_debug_req_o,
    output core_irq_o,
    input  core_debug_halted_i,
    input  core_sleep_i,
    input  core_irq_ack_i,
    input  core_irq_id_i
  );

  modport slave (
    input  core_debug_req_o,
    input  core_irq_o,
    output core_debug_halted_i,
    output core_sleep_i,
    output core_irq_ack_i,
    output core_irq_id_i
  );

endinterface

`default_nettype wire

// File: rtl/safe_wfi_filter.sv
// ============================================================================
// Module  : safe_wfi_filter
// Brief   : Saturating glitch filter turning core_sleep_i into a WFI flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module safe_wfi_filter #(
  parameter int WFI_FILTER = 2
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic core_sleep_i,
  output logic      hart_wfi_o
);

  localparam logic [3:0] c_FILT = 4'(WFI_FILTER);

  logic [3:0] r_cnt;
  logic       r_wfi;

  // Qualifying with the live sleep input gives a one-edge fall latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 4'd0;
      r_wfi <= 1'b0;
    end else begin
      if (!core_sleep_i) begin
        r_cnt <= 4'd0;
      end else if (r_cnt != c_FILT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      r_wfi <= core_sleep_i && (r_cnt == c_FILT);
    end
  end

  assign hart_wfi_o = r_wfi;

endmodule

`default_nettype wire

// File: rtl/safe_hart_sync_agent.sv
// ============================================================================
// Module  : safe_hart_sync_agent
// Brief   : Per-hart responder turning controller halt/sync levels into core
//           debug-halt and IRQ handshakes, with timeout and WFI reporting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module safe_hart_sync_agent
  import safe_pkg::*;
#(
  parameter logic [4:0] SYNC_IRQ_ID    = SAFE_SYNC_IRQ_ID,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         WFI_FILTER     = 2
) (
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  input  wire logic               Interrupt_Halt_i,
  input  wire logic               Interrupt_Sync_i,
  output logic                    Halt_ack_o,
  output logic                    Hart_wfi_o,
  output logic                    Hart_intc_ack_o,
  input  wire logic               timeout_clr_i,
  output logic                    timeout_o,
  safe_hart_sync_agent_if.master  core
);

  localparam int             c_TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES);

  safe_agent_fsm_e   r_state;
  safe_agent_fsm_e   w_state_nxt;
  logic [c_TO_W-1:0] r_to_cnt;
  logic [c_TO_W-1:0] w_to_inc;
  logic              w_to_hit;
  logic              w_to_abort;
  logic              r_debug_req;
  logic              r_irq;
  logic              r_halt_ack;
  logic              r_intc_ack;
  logic              r_timeout;

  assign w_to_inc = r_to_cnt + 1'b1;
  // The abort fires on the cycle the count would reach the limit, so a
  // request is presented for exactly TIMEOUT_CYCLES cycles.
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && (w_to_inc == c_TO_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_to_abort  = 1'b0;
    case (r_state)
      AG_IDLE: begin
        if (Interrupt_Halt_i)      w_state_nxt = AG_HALT_REQ;
        else if (Interrupt_Sync_i) w_state_nxt = AG_IRQ_REQ;
      end
      AG_HALT_REQ: begin
        if (core.core_debug_halted_i) begin
          w_state_nxt = AG_HALT_ACK;
        end else if (!Interrupt_Halt_i) begin
          w_state_nxt = AG_IDLE;
        end else if (w_to_hit) begin
          w_state_nxt = AG_IDLE;
          w_to_abort  = 1'b1;
        end
      end
      AG_HALT_ACK: begin
        if (!Interrupt_Halt_i) w_state_nxt = AG_IDLE;
      end
      AG_IRQ_REQ: begin
        if (core.core_irq_ack_i && (core.core_irq_id_i == SYNC_IRQ_ID)) begin
          w_state_nxt = AG_IRQ_ACK;
        end else if (!Interrupt_Sync_i) begin
          w_state_nxt = AG_IDLE;
        end else if (w_to_hit) begin
          w_state_nxt = AG_IDLE;
          w_to_abort  = 1'b1;
        end
      end
      AG_IRQ_ACK: begin
        if (!Interrupt_Sync_i) w_state_nxt = AG_IDLE;
      end
      default: w_state_nxt = AG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= AG_IDLE;
      r_to_cnt    <= '0;
      r_debug_req <= 1'b0;
      r_irq       <= 1'b0;
      r_halt_ack  <= 1'b0;
      r_intc_ack  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_debug_req <= (w_state_nxt == AG_HALT_REQ);
      r_irq       <= (w_state_nxt == AG_IRQ_REQ);
      r_halt_ack  <= (w_state_nxt == AG_HALT_ACK);
      r_intc_ack  <= (w_state_nxt == AG_IRQ_ACK);
      if ((w_state_nxt == r_state) &&
          ((r_state == AG_HALT_REQ) || (r_state == AG_IRQ_REQ))) begin
        r_to_cnt <= w_to_inc;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_to_abort)         r_timeout <= 1'b1;
      else if (timeout_clr_i) r_timeout <= 1'b0;
    end
  end

  assign core.core_debug_req_o = r_debug_req;
  assign core.core_irq_o       = r_irq;
  assign Halt_ack_o            = r_halt_ack;
  assign Hart_intc_ack_o       = r_intc_ack;
  assign timeout_o             = r_timeout;

  safe_wfi_filter #(
    .WFI_FILTER (WFI_FILTER)
  ) u_wfi_filter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_sleep_i (core.core_sleep_i),
    .hart_wfi_o   (Hart_wfi_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_safe_hart_sync_agent.sv
// ============================================================================
// Module  : tb_safe_hart_sync_agent
// Brief   : Directed self-checking bench for safe_hart_sync_agent.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_safe_hart_sync_agent;

  logic clk_i;
  logic rst_ni;
  logic Interrupt_Halt_i;
  logic Interrupt_Sync_i;
  logic Halt_ack_o;
  logic Hart_wfi_o;
  logic Hart_intc_ack_o;
  logic timeout_clr_i;
  logic timeout_o;

  int n_cmp;
  int n_err;

  safe_hart_sync_agent_if core_if ();

  safe_hart_sync_agent #(
    .SYNC_IRQ_ID    (5'd31),
    .TIMEOUT_CYCLES (8),
    .WFI_FILTER     (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .Interrupt_Halt_i (Interrupt_Halt_i),
    .Interrupt_Sync_i (Interrupt_Sync_i),
    .Halt_ack_o       (Halt_ack_o),
    .Hart_wfi_o       (Hart_wfi_o),
    .Hart_intc_ack_o  (Hart_intc_ack_o),
    .timeout_clr_i    (timeout_clr_i),
    .timeout_o        (timeout_o),
    .core             (core_if)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    Interrupt_Halt_i = 1'b0;
    Interrupt_Sync_i = 1'b0;
    timeout_clr_i = 1'b0;
    core_if.core_debug_halted_i = 1'b0;
    core_if.core_sleep_i = 1'b0;
    core_if.core_irq_ack_i = 1'b0;
    core_if.core_irq_id_i = 5'd0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    n_cmp++; if (core_if.core_debug_req_o !== 1'b0) begin n_err++; $display("FAIL reset_debug_req: got %b expected 0", core_if.core_debug_req_o); end
    n_cmp++; if (core_if.core_irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", core_if.core_irq_o); end
    n_cmp++; if (Halt_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_halt_ack: got %b expected 0", Halt_ack_o); end
    n_cmp++; if (Hart_intc_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_intc_ack: got %b expected 0", Hart_intc_ack_o); end
    n_cmp++; if (Hart_wfi_o !== 1'b0) begin n_err++; $display("FAIL reset_wfi: got %b expected 0", Hart_wfi_o); end
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
  endtask

  task automatic test_halt();
    Interrupt_Halt_i = 1'b1;
    tick();
    n_cmp++; if (core_if.core_debug_req_o !== 1'b1) begin n_err++; $display("FAIL halt_req_rise: got %b expected 1", core_if.core_debug_req_o); end
    tick(); tick();
    n_cmp++; if (core_if.core_debug_req_o !== 1'b1 || Halt_ack_o !== 1'b0) begin n_err++; $display("FAIL halt_req_hold: got req=%b ack=%b expected req=1 ack=0", core_if.core_debug_req_o, Halt_ack_o); end
    tick();
    core_if.core_debug_halted_i = 1'b1;
    tick();
    n_cmp++; if (Halt_ack_o !== 1'b1 || core_if.core_debug_req_o !== 1'b0) begin n_err++; $display("FAIL halt_ack: got ack=%b req=%b expected ack=1 req=0", Halt_ack_o, core_if.core_debug_req_o); end
    core_if.core_debug_halted_i = 1'b0;
    tick();
    n_cmp++; if (Halt_ack_o !== 1'b1) begin n_err++; $display("FAIL halt_ack_held: got %b expected 1", Halt_ack_o); end
    Interrupt_Halt_i = 1'b0;
    tick();
    n_cmp++; if (Halt_ack_o !== 1'b0 || timeout_o !== 1'b0) begin n_err++; $display("FAIL halt_ack_drop: got ack=%b to=%b expected ack=0 to=0", Halt_ack_o, timeout_o); end
  endtask

  task automatic test_sync();
    Interrupt_Sync_i = 1'b1;
    tick();
    n_cmp++; if (core_if.core_irq_o !== 1'b1) begin n_err++; $display("FAIL sync_irq_rise: got %b expected 1", core_if.core_irq_o); end
    core_if.core_irq_ack_i = 1'b1;
    core_if.core_irq_id_i = 5'd3;
    tick();
    core_if.core_irq_ack_i = 1'b0;
    n_cmp++; if (core_if.core_irq_o !== 1'b1 || Hart_intc_ack_o !== 1'b0) begin n_err++; $display("FAIL sync_wrong_id: got irq=%b ack=%b expected irq=1 ack=0", core_if.core_irq_o, Hart_intc_ack_o); end
    tick();
    core_if.core_irq_ack_i = 1'b1;
    core_if.core_irq_id_i = 5'd31;
    tick();
    core_if.core_irq_ack_i = 1'b0;
    n_cmp++; if (Hart_intc_ack_o !== 1'b1 || core_if.core_irq_o !== 1'b0) begin n_err++; $display("FAIL sync_ack: got ack=%b irq=%b expected ack=1 irq=0", Hart_intc_ack_o, core_if.core_irq_o); end
    Interrupt_Sync_i = 1'b0;
    tick();
    n_cmp++; if (Hart_intc_ack_o !== 1'b0 || core_if.core_irq_o !== 1'b0) begin n_err++; $display("FAIL sync_drop: got ack=%b irq=%b expected 0 0", Hart_intc_ack_o, core_if.core_irq_o); end
    Interrupt_Sync_i = 1'b1;
    tick();
    n_cmp++; if (core_if.core_irq_o !== 1'b1 || Hart_intc_ack_o !== 1'b0) begin n_err++; $display("FAIL sync_reassert: got irq=%b ack=%b expected irq=1 ack=0", core_if.core_irq_o, Hart_intc_ack_o); end
    Interrupt_Sync_i = 1'b0;
    tick();
    n_cmp++; if (core_if.core_irq_o !== 1'b0 || timeout_o !== 1'b0) begin n_err++; $display("FAIL sync_abort: got irq=%b to=%b expected 0 0", core_if.core_irq_o, timeout_o); end
  endtask

  task automatic test_priority();
    Interrupt_Halt_i = 1'b1;
    Interrupt_Sync_i = 1'b1;
    tick();
    n_cmp++; if (core_if.core_debug_req_o !== 1'b1 || core_if.core_irq_o !== 1'b0) begin n_err++; $display("FAIL prio_first: got req=%b irq=%b expected req=1 irq=0", core_if.core_debug_req_o, core_if.core_irq_o); end
    tick(); tick();
    n_cmp++; if (core_if.core_irq_o !== 1'b0) begin n_err++; $display("FAIL prio_hold: got irq=%b expected 0", core_if.core_irq_o); end
    Interrupt_Halt_i = 1'b0;
    Interrupt_Sync_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    Interrupt_Halt_i = 1'b1;
    tick();
    n = 0;
    while (core_if.core_debug_req_o === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    Interrupt_Halt_i = 1'b0;
    n_cmp++; if (n != 8) begin n_err++; $display("FAIL timeout_req_cycles: got %0d expected 8", n); end
    n_cmp++; if (timeout_o !== 1'b1 || Halt_ack_o !== 1'b0) begin n_err++; $display("FAIL timeout_set: got to=%b ack=%b expected to=1 ack=0", timeout_o, Halt_ack_o); end
    tick();
    n_cmp++; if (timeout_o !== 1'b1 || core_if.core_debug_req_o !== 1'b0) begin n_err++; $display("FAIL timeout_sticky: got to=%b req=%b expected to=1 req=0", timeout_o, core_if.core_debug_req_o); end
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b expected 0", timeout_o); end
  endtask

  task automatic test_wfi();
    core_if.core_sleep_i = 1'b1;
    tick();
    core_if.core_sleep_i = 1'b0;
    tick();
    n_cmp++; if (Hart_wfi_o !== 1'b0) begin n_err++; $display("FAIL wfi_glitch: got %b expected 0", Hart_wfi_o); end
    tick();
    core_if.core_sleep_i = 1'b1;
    tick();
    n_cmp++; if (Hart_wfi_o !== 1'b0) begin n_err++; $display("FAIL wfi_edge1: got %b expected 0", Hart_wfi_o); end
    tick();
    n_cmp++; if (Hart_wfi_o !== 1'b0) begin n_err++; $display("FAIL wfi_edge2: got %b expected 0", Hart_wfi_o); end
    tick();
    n_cmp++; if (Hart_wfi_o !== 1'b1) begin n_err++; $display("FAIL wfi_edge3: got %b expected 1", Hart_wfi_o); end
    tick();
    n_cmp++; if (Hart_wfi_o !== 1'b1) begin n_err++; $display("FAIL wfi_hold: got %b expected 1", Hart_wfi_o); end
    core_if.core_sleep_i = 1'b0;
    tick();
    n_cmp++; if (Hart_wfi_o !== 1'b0) begin n_err++; $display("FAIL wfi_fall: got %b expected 0", Hart_wfi_o); end
  endtask

  task automatic test_reset_mid();
    Interrupt_Sync_i = 1'b1;
    tick();
    n_cmp++; if (core_if.core_irq_o !== 1'b1) begin n_err++; $display("FAIL rstmid_irq_before: got %b expected 1", core_if.core_irq_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (core_if.core_irq_o !== 1'b0) begin n_err++; $display("FAIL rstmid_irq_async: got %b expected 0", core_if.core_irq_o); end
    Interrupt_Sync_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    n_cmp++; if (core_if.core_irq_o !== 1'b0 || core_if.core_debug_req_o !== 1'b0 || Hart_intc_ack_o !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got irq=%b req=%b ack=%b expected 0 0 0", core_if.core_irq_o, core_if.core_debug_req_o, Hart_intc_ack_o); end
    Interrupt_Sync_i = 1'b1;
    tick();
    n_cmp++; if (core_if.core_irq_o !== 1'b1) begin n_err++; $display("FAIL rstmid_restart: got %b expected 1", core_if.core_irq_o); end
    Interrupt_Sync_i = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_halt();
    test_sync();
    test_priority();
    test_timeout();
    test_wfi();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
